// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control unit's host-memory port arbitration.
package ctrl_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 512;
  localparam int unsigned NUM_RD    = 4;
  localparam int unsigned NUM_SLOTS = NUM_RD + 1;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } arb_state_t;

  // Arbitration slot indices; the write port always sits after the read ports.
  localparam logic [2:0] SLOT_PROG = 3'd0;
  localparam logic [2:0] SLOT_RDN  = 3'd1;
  localparam logic [2:0] SLOT_DNN  = 3'd2;
  localparam logic [2:0] SLOT_IMG  = 3'd3;
  localparam logic [2:0] SLOT_WR   = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or above ptr wins,
// wrapping to the lowest requesting index overall.
module rr_arbiter #(
  parameter int unsigned N  = 5,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] idx_c,
  output logic          any_grant_c
);

  logic [N-1:0] mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] pick_src;

  always_comb begin
    mask        = ~((N'(1) << ptr) - N'(1));
    req_hi      = req & mask;
    pick_src    = (|req_hi) ? req_hi : req;
    // isolate the lowest set bit
    grant_c     = pick_src & (~pick_src + N'(1));
    any_grant_c = |req;
    idx_c       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_c[i]) idx_c = IW'(i);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single host-memory port between the read requesters and the write-back
// port; one transaction at a time, round-robin, with a bubble cycle after each ack.
module mem_port_arbiter #(
  parameter int unsigned NUM_RD = ctrl_pkg::NUM_RD,
  parameter int unsigned ADDR_W = ctrl_pkg::ADDR_W,
  parameter int unsigned DATA_W = ctrl_pkg::DATA_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           buffer_addr_valid,
  input  logic [NUM_RD-1:0]              rd_req,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0]              rd_ack,
  output logic [DATA_W-1:0]              rd_data,
  input  logic                           wr_req,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  output logic                           wr_ack,
  output logic [ADDR_W-1:0]              address,
  output logic [DATA_W-1:0]              write_data,
  output logic                           read_request_valid,
  output logic                           write_request_valid,
  input  logic                           data_valid,
  input  logic [DATA_W-1:0]              read_data,
  input  logic                           write_done,
  output logic                           busy,
  output logic                           proto_err
);

  import ctrl_pkg::*;

  localparam int unsigned NSLOT  = NUM_RD + 1;
  localparam int unsigned SLOT_W = $clog2(NSLOT);

  arb_state_t          state_q, state_d;
  logic [SLOT_W-1:0]   winner_q, winner_d;
  logic [SLOT_W-1:0]   ptr_q, ptr_d;
  logic                enabled_q, enabled_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]   rd_ack_q, rd_ack_d;
  logic                wr_ack_q, wr_ack_d;
  logic                rrv_q, rrv_d;
  logic                wrv_q, wrv_d;
  logic                busy_q, busy_d;
  logic                proto_err_q, proto_err_d;

  logic [NSLOT-1:0]    grant_c;
  logic [SLOT_W-1:0]   grant_idx_c;
  logic                any_grant_c;
  logic [ADDR_W-1:0]   rd_addr_sel;

  rr_arbiter #(
    .N  (NSLOT),
    .IW (SLOT_W)
  ) u_rr (
    .req         ({wr_req, rd_req}),
    .ptr         (ptr_q),
    .grant_c     (grant_c),
    .idx_c       (grant_idx_c),
    .any_grant_c (any_grant_c)
  );

  // Address of the winning read port
  always_comb begin
    rd_addr_sel = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (grant_c[k]) rd_addr_sel = rd_addr[k];
    end
  end

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    ptr_d        = ptr_q;
    enabled_d    = enabled_q | buffer_addr_valid;
    address_d    = address_q;
    write_data_d = write_data_q;
    rd_data_d    = rd_data_q;
    rd_ack_d     = '0;
    wr_ack_d     = 1'b0;
    rrv_d        = rrv_q;
    wrv_d        = wrv_q;
    proto_err_d  = proto_err_q;

    unique case (state_q)
      IDLE: begin
        if (data_valid || write_done) proto_err_d = 1'b1;
        // Hold off while an ack is visible so the requester can drop its request.
        if (enabled_q && any_grant_c && !(|rd_ack_q) && !wr_ack_q) begin
          winner_d = grant_idx_c;
          if (grant_c[NUM_RD]) begin
            address_d    = wr_addr;
            write_data_d = wr_data;
            wrv_d        = 1'b1;
            state_d      = WR_WAIT;
          end else begin
            address_d = rd_addr_sel;
            rrv_d     = 1'b1;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (write_done) proto_err_d = 1'b1;
        if (data_valid) begin
          rd_data_d = read_data;
          rd_ack_d  = NUM_RD'(1) << winner_q;
          rrv_d     = 1'b0;
          ptr_d     = (winner_q == SLOT_W'(NSLOT - 1)) ? '0 : winner_q + SLOT_W'(1);
          state_d   = IDLE;
        end
      end
      WR_WAIT: begin
        if (data_valid) proto_err_d = 1'b1;
        if (write_done) begin
          wr_ack_d = 1'b1;
          wrv_d    = 1'b0;
          ptr_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      winner_q     <= '0;
      ptr_q        <= '0;
      enabled_q    <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      rd_data_q    <= '0;
      rd_ack_q     <= '0;
      wr_ack_q     <= 1'b0;
      rrv_q        <= 1'b0;
      wrv_q        <= 1'b0;
      busy_q       <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      ptr_q        <= ptr_d;
      enabled_q    <= enabled_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      rd_data_q    <= rd_data_d;
      rd_ack_q     <= rd_ack_d;
      wr_ack_q     <= wr_ack_d;
      rrv_q        <= rrv_d;
      wrv_q        <= wrv_d;
      busy_q       <= busy_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign rd_ack              = rd_ack_q;
  assign rd_data             = rd_data_q;
  assign wr_ack              = wr_ack_q;
  assign address             = address_q;
  assign write_data          = write_data_q;
  assign read_request_valid  = rrv_q;
  assign write_request_valid = wrv_q;
  assign busy                = busy_q;
  assign proto_err           = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requester traffic, a simple memory
// responder, and a monitor that checks every ack against the expected grant order.
module tb_mem_port_arbiter;

  localparam int unsigned NUM_RD = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 512;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          buffer_addr_valid;
  logic [NUM_RD-1:0]             rd_req;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]             rd_ack;
  logic [DATA_W-1:0]             rd_data;
  logic                          wr_req;
  logic [ADDR_W-1:0]             wr_addr;
  logic [DATA_W-1:0]             wr_data;
  logic                          wr_ack;
  logic [ADDR_W-1:0]             address;
  logic [DATA_W-1:0]             write_data;
  logic                          read_request_valid;
  logic                          write_request_valid;
  logic                          data_valid;
  logic [DATA_W-1:0]             read_data;
  logic                          write_done;
  logic                          busy;
  logic                          proto_err;

  typedef struct {
    int          slot;
    logic [31:0] addr;
    logic [511:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails  = 0;
  int          target[5];
  int          served[5];
  bit          mem_auto;
  int          mem_lat;
  logic        dv_auto, dv_inj, wd_auto, wd_inj;
  logic [4:0]  req_v;
  bit          seen;

  assign rd_req     = req_v[3:0];
  assign wr_req     = req_v[4];
  assign data_valid = dv_auto | dv_inj;
  assign write_done = wd_auto | wd_inj;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .buffer_addr_valid   (buffer_addr_valid),
    .rd_req              (rd_req),
    .rd_addr             (rd_addr),
    .rd_ack              (rd_ack),
    .rd_data             (rd_data),
    .wr_req              (wr_req),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .wr_ack              (wr_ack),
    .address             (address),
    .write_data          (write_data),
    .read_request_valid  (read_request_valid),
    .write_request_valid (write_request_valid),
    .data_valid          (data_valid),
    .read_data           (read_data),
    .write_done          (write_done),
    .busy                (busy),
    .proto_err           (proto_err)
  );

  function automatic logic [511:0] mem_word(input logic [31:0] a);
    return (a == 32'h2000) ? {64{8'hA5}} : {16{a}};
  endfunction

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int s, input logic [31:0] a, input logic [511:0] d);
    exp_t e;
    e.slot = s;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rrv(input string nm);
    int i;
    i = 0;
    while (!read_request_valid && i < 20) begin
      cyc(1);
      i++;
    end
    check(nm, 512'(read_request_valid), 512'(1));
  endtask

  function automatic bit reqs_idle();
    for (int s = 0; s < 5; s++) if (target[s] > served[s]) return 1'b0;
    return (req_v == 5'b0);
  endfunction

  task automatic drain(input string nm);
    int i;
    i = 0;
    while (!(sb.size() == 0 && reqs_idle()) && i < 300) begin
      cyc(1);
      i++;
    end
    check(nm, 512'(sb.size()), 512'(0));
  endtask

  task automatic pulse_bav();
    buffer_addr_valid = 1'b1;
    cyc(1);
    buffer_addr_valid = 1'b0;
  endtask

  // Memory model: answers an outstanding request after mem_lat cycles.
  task automatic mem_thread();
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      dv_auto = 1'b0;
      wd_auto = 1'b0;
      if (!rst_n) cnt = 0;
      else if (mem_auto && (read_request_valid || write_request_valid)) begin
        cnt++;
        if (cnt >= mem_lat) begin
          if (read_request_valid) begin
            read_data = mem_word(address);
            dv_auto   = 1'b1;
          end else begin
            wd_auto = 1'b1;
          end
          cnt = 0;
        end
      end else cnt = 0;
    end
  endtask

  // Requesters: raise while work is pending, drop on the ack, re-raise a cycle later.
  task automatic req_thread();
    logic [4:0] ackv;
    forever begin
      @(negedge clk);
      ackv = {wr_ack, rd_ack};
      if (!rst_n) req_v = '0;
      else begin
        for (int s = 0; s < 5; s++) begin
          if (ackv[s]) begin
            req_v[s] = 1'b0;
            served[s]++;
          end else if (target[s] <= served[s]) req_v[s] = 1'b0;
          else req_v[s] = 1'b1;
        end
      end
    end
  endtask

  task automatic mon_thread();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (rd_ack != '0 || wr_ack)) begin
        if (sb.size() == 0) begin
          check("spurious_ack", 512'({wr_ack, rd_ack}), 512'(0));
        end else begin
          e = sb.pop_front();
          check("ack_vec", 512'({wr_ack, rd_ack}), 512'(5'b1 << e.slot));
          check("ack_addr", 512'(address), 512'(e.addr));
          if (e.slot == 4) check("wr_data", write_data, e.data);
          else check("rd_data", rd_data, e.data);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; buffer_addr_valid = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    dv_auto = 1'b0; dv_inj = 1'b0; wd_auto = 1'b0; wd_inj = 1'b0; read_data = '0;
    req_v = '0; mem_auto = 1'b1; mem_lat = 3;
    for (int s = 0; s < 5; s++) begin target[s] = 0; served[s] = 0; end

    fork
      mem_thread();
      req_thread();
      mon_thread();
      begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    cyc(3);
    check("rst_rrv", 512'(read_request_valid), 512'(0));
    check("rst_wrv", 512'(write_request_valid), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_perr", 512'(proto_err), 512'(0));
    check("rst_ack", 512'({wr_ack, rd_ack}), 512'(0));
    check("rst_addr", 512'(address), 512'(0));
    rst_n = 1'b1;

    // Enable gating
    rd_addr[0] = 32'h100;
    push(0, 32'h100, {16{32'h100}});
    target[0] = 1;
    seen = 1'b0;
    repeat (10) begin cyc(1); if (read_request_valid) seen = 1'b1; end
    check("gate_no_req", 512'(seen), 512'(0));
    pulse_bav();
    wait_rrv("gate_req");
    check("gate_addr", 512'(address), 512'(32'h100));
    drain("gate_drain");

    // Single read with slow memory
    mem_lat = 5;
    rd_addr[1] = 32'h2000;
    push(1, 32'h2000, {64{8'hA5}});
    target[1]++;
    drain("single_drain");
    check("single_busy", 512'(busy), 512'(0));
    cyc(2);
    check("single_hold", rd_data, {64{8'hA5}});

    // Round-robin from pointer 0
    mem_lat = 3;
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    pulse_bav();
    rd_addr[0] = 32'h1000; rd_addr[1] = 32'h1100; rd_addr[2] = 32'h1200; rd_addr[3] = 32'h1300;
    wr_addr = 32'h4000;
    wr_data = {16{32'hDEADBEEF}};
    push(0, 32'h1000, {16{32'h1000}});
    push(1, 32'h1100, {16{32'h1100}});
    push(2, 32'h1200, {16{32'h1200}});
    push(3, 32'h1300, {16{32'h1300}});
    push(4, 32'h4000, {16{32'hDEADBEEF}});
    push(0, 32'h1000, {16{32'h1000}});
    target[0] += 2; target[1]++; target[2]++; target[3]++; target[4]++;
    drain("rr_drain");

    // Protocol errors
    mem_auto = 1'b0;
    cyc(1);
    dv_inj = 1'b1; cyc(1); dv_inj = 1'b0;
    cyc(2);
    check("perr_idle", 512'(proto_err), 512'(1));
    check("perr_no_ack", 512'({wr_ack, rd_ack}), 512'(0));
    rd_addr[1] = 32'h3000;
    push(1, 32'h3000, {16{32'h3000}});
    target[1]++;
    wait_rrv("perr_rd_req");
    wd_inj = 1'b1; cyc(1); wd_inj = 1'b0;
    cyc(1);
    check("perr_still_rd", 512'(read_request_valid), 512'(1));
    check("perr_still_busy", 512'(busy), 512'(1));
    mem_auto = 1'b1;
    drain("perr_drain");
    check("perr_sticky", 512'(proto_err), 512'(1));

    // Reset during RD_WAIT
    mem_auto = 1'b0;
    rd_addr[2] = 32'h5000;
    target[2]++;
    wait_rrv("mid_rd_req");
    cyc(1);
    rst_n = 1'b0;
    #1;
    check("mid_rrv", 512'(read_request_valid), 512'(0));
    check("mid_busy", 512'(busy), 512'(0));
    check("mid_ack", 512'({wr_ack, rd_ack}), 512'(0));
    check("mid_perr", 512'(proto_err), 512'(0));
    target[2] = served[2];
    cyc(2);
    rst_n = 1'b1;
    rd_addr[3] = 32'h6000;
    push(3, 32'h6000, {16{32'h6000}});
    target[3]++;
    seen = 1'b0;
    repeat (8) begin cyc(1); if (read_request_valid) seen = 1'b1; end
    check("mid_gate", 512'(seen), 512'(0));
    mem_auto = 1'b1;
    pulse_bav();
    drain("mid_drain");

    // Early drop: ack still issued, then pointer moves past the dropped slot
    mem_lat = 4;
    rd_addr[2] = 32'h7000; rd_addr[3] = 32'h7300; rd_addr[0] = 32'h7100;
    push(2, 32'h7000, {16{32'h7000}});
    push(3, 32'h7300, {16{32'h7300}});
    push(0, 32'h7100, {16{32'h7100}});
    target[2]++;
    wait_rrv("drop_rd_req");
    check("drop_addr", 512'(address), 512'(32'h7000));
    target[3]++;
    target[0]++;
    target[2] = served[2];
    drain("drop_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 512-bit host-memory read/write port between the control unit's requesters: program fetch, RDN weight load, DNN weight load, image page load (read ports) and DNN result write-back (one write port).
- Sits between ctrl_unit sequencing logic and the memory interface.
- Issues one memory transaction at a time, arbitrated round-robin, and returns read data plus a per-port completion pulse.

Parameters:
NUM_RD, 4, number of read requester ports (index 0 = program fetch, 1 = RDN, 2 = DNN, 3 = image)
ADDR_W, 32, memory address width
DATA_W, 512, memory data width (one cache line)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
buffer_addr_valid  in  1  host buffer ready; arbitration is disabled until first seen
rd_req  in  NUM_RD  per-port read request, level, held until rd_ack
rd_addr  in  NUM_RD x ADDR_W  per-port read address, stable while rd_req high
rd_ack  out  NUM_RD  one-cycle completion pulse, one-hot
rd_data  out  DATA_W  registered read data, valid with rd_ack, held until next read completes
wr_req  in  1  write request, level, held until wr_ack
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ack  out  1  one-cycle write completion pulse
address  out  ADDR_W  memory address (registered)
write_data  out  DATA_W  memory write data (registered)
read_request_valid  out  1  memory read request, held until data_valid
write_request_valid  out  1  memory write request, held until write_done
data_valid  in  1  memory read data valid
read_data  in  DATA_W  memory read data
write_done  in  1  memory write complete
busy  out  1  transaction in flight (state != IDLE)
proto_err  out  1  sticky: data_valid or write_done arrived with no matching request outstanding

Behaviour:
- Reset (async, any state): state IDLE, all outputs 0, enabled flag 0, rr pointer 0, proto_err 0. Any in-flight transaction is abandoned without an ack.
- enabled: a sticky flag, set at the first clock edge with buffer_addr_valid = 1. No grant is made while it is 0.
- Arbitration candidates: NUM_RD+1 slots; slot NUM_RD is the write port.
- Arbitration is round-robin. Search starts at the rr pointer and wraps modulo NUM_RD+1.
- States:
  - IDLE: arbitrates when enabled, any request is high, and rd_ack/wr_ack are both low (one-cycle bubble after every completion, so the requester drops its request first).
    - On a read winner k: latch winner, address<=rd_addr[k], read_request_valid<=1, go to RD_WAIT.
    - On a write winner: address<=wr_addr, write_data<=wr_data, write_request_valid<=1, go to WR_WAIT.
  - RD_WAIT: on data_valid, rd_data<=read_data, rd_ack[k]<=1 for one cycle, read_request_valid<=0, rr pointer<=k+1 (wrapping), go to IDLE. write_done in this state sets proto_err and is otherwise ignored.
  - WR_WAIT: on write_done, wr_ack<=1 for one cycle, write_request_valid<=0, rr pointer<=NUM_RD+1 wrapped to 0, go to IDLE. data_valid in this state sets proto_err and is otherwise ignored.
- data_valid or write_done in IDLE: sets proto_err, otherwise ignored.
- Latency:
  - request high in IDLE at cycle N -> read_request_valid/write_request_valid high at N+1.
  - completion sampled at cycle M -> ack and rd_data visible at M+1.
  - earliest next grant at M+2.
- Requester rule: drop the request at the edge where ack is seen high; re-raise one or more cycles later for the next transaction.
- Request deasserted before ack: the transaction still completes and the ack is still issued.
- Memory-side address and data are registered at grant and never change during a transaction.
- Single requester continuously requesting: served every 3 cycles plus memory latency.
- Fairness: no slot waits for more than NUM_RD other transactions.

Decomposition:
- Shared package (ctrl_pkg): arb_state_t enum {IDLE, RD_WAIT, WR_WAIT}, slot index constants (SLOT_PROG, SLOT_RDN, SLOT_DNN, SLOT_IMG, SLOT_WR), DATA_W/ADDR_W localparams.
- Sub-module rr_arbiter (parameter N): inputs req vector and pointer; outputs one-hot grant, encoded index, any_grant. Purely combinational, reusable.

Test Plan:
1. Enable gating: rd_req[0]=1, addr 0x100, buffer_addr_valid=0 for 10 cycles -> no read_request_valid. Pulse buffer_addr_valid -> read_request_valid high next cycle, address=0x100.
2. Single read: rd_req[1] addr 0x2000; memory returns data_valid after 5 cycles with data 0xA5..A5 -> rd_ack=4'b0010 for exactly one cycle, rd_data=0xA5..A5, busy low after ack.
3. Round-robin: all four rd_req plus wr_req held high from pointer 0, each requester re-raising after its ack -> grant order 0,1,2,3,W,0; wr_ack fires with address=wr_addr and write_data=wr_data.
4. Protocol error: data_valid pulsed in IDLE -> proto_err=1 sticky, no ack. write_done during RD_WAIT -> still in RD_WAIT, proto_err stays 1.
5. Reset mid-op: assert rst_n=0 during RD_WAIT -> read_request_valid and all acks drop immediately, state IDLE. After release, no request is issued until buffer_addr_valid is seen again.
6. Early drop: rd_req[2] deasserted during RD_WAIT -> rd_ack[2] still pulses on data_valid, and the next grant goes to slot 3.
